// File: rtl/clmul_iter_unit.sv
// Iterative carry-less multiplier (Zbc clmul/clmulh/clmulr) for the EX stage.
// Processes STEP bits of rs2 per cycle and stalls the upstream pipeline until the result is ready.
module clmul_iter_unit #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic        flush,
    output logic [31:0] result,
    output logic        done,
    output logic        stall,
    output logic        busy
);

    localparam int ITER = 32 / STEP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [63:0] a;
    logic [63:0] acc;
    logic [63:0] acc_step;
    logic [31:0] b;
    logic [5:0]  cnt;
    logic [1:0]  op_q;
    logic        last;
    logic [31:0] sel;

    assign last = (cnt == 6'(ITER - 1));

    // Partial products for this cycle's slice of b, folded onto the running accumulator.
    always_comb begin
        acc_step = acc;
        for (int j = 0; j < STEP; j++) begin
            if (b[j]) acc_step = acc_step ^ (a << j);
        end
    end

    always_comb begin
        unique case (op_q)
            2'b01:   sel = acc_step[63:32];
            2'b10:   sel = acc_step[62:31];
            default: sel = acc_step[31:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // NOTE: stall is decoded from state and start only; feeding done or result back
    // into it would close a combinational loop through the pipeline enables.
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                stall = start;
                if (start) state_nx = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= '0;
            result <= '0;
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a    <= {32'd0, rs1_val};
                        b    <= rs2_val;
                        op_q <= op;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    a   <= a << STEP;
                    b   <= b >> STEP;
                    cnt <= cnt + 6'd1;
                    if (last) result <= sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clmul_iter_unit.sv
// Directed bench for clmul_iter_unit: three instances (STEP=4, 1, 32) sharing operands,
// each with its own start; expected results are hand-computed carry-less products.
module tb_clmul_iter_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [2:0]  start_v = '0;
    logic [2:0]  done_v;
    logic [2:0]  stall_v;
    logic [2:0]  busy_v;
    logic [31:0] result_v [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clmul_iter_unit #(.STEP(4)) u_step4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .op(op), .rs1_val(rs1), .rs2_val(rs2),
        .flush(flush), .result(result_v[0]), .done(done_v[0]), .stall(stall_v[0]), .busy(busy_v[0])
    );

    clmul_iter_unit #(.STEP(1)) u_step1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .op(op), .rs1_val(rs1), .rs2_val(rs2),
        .flush(flush), .result(result_v[1]), .done(done_v[1]), .stall(stall_v[1]), .busy(busy_v[1])
    );

    clmul_iter_unit #(.STEP(32)) u_step32 (
        .clk(clk), .rst(rst), .start(start_v[2]), .op(op), .rs1_val(rs1), .rs2_val(rs2),
        .flush(flush), .result(result_v[2]), .done(done_v[2]), .stall(stall_v[2]), .busy(busy_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one instruction on instance sel, holding start through DONE like the pipeline does,
    // then drop start and confirm the unit went back to IDLE without restarting.
    task automatic run_op(input int sel, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_stall,
                          input bit scramble, input string tag);
        int          stalls = 0;
        bit          got = 1'b0;
        logic [31:0] res = '0;
        start_v      = '0;
        start_v[sel] = 1'b1;
        op  = o;
        rs1 = x;
        rs2 = y;
        for (int c = 0; c < 100 && !got; c++) begin
            #1;
            if (stall_v[sel]) stalls++;
            if (done_v[sel]) begin
                got = 1'b1;
                res = result_v[sel];
            end else begin
                @(negedge clk);
                if (scramble) begin
                    op  = ~o;
                    rs1 = ~x;
                    rs2 = ~y;
                end
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_result"}, res, exp);
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        @(negedge clk);
        start_v = '0;
        op  = o;
        rs1 = x;
        rs2 = y;
        #1;
        check({tag, "_post_busy"}, 32'(busy_v[sel]), 32'd0);
        check({tag, "_post_done"}, 32'(done_v[sel]), 32'd0);
        check({tag, "_post_stall"}, 32'(stall_v[sel]), 32'd0);
        check({tag, "_post_hold"}, result_v[sel], exp);
    endtask

    initial begin
        int d;

        // Reset state on all instances
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset%0d_result", i), result_v[i], 32'd0);
            check($sformatf("reset%0d_done", i), 32'(done_v[i]), 32'd0);
            check($sformatf("reset%0d_busy", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset%0d_stall", i), 32'(stall_v[i]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // STEP=4: basic and back-to-back ops
        run_op(0, 2'b00, 32'd3, 32'd3, 32'h0000_0005, 9, 1'b0, "s4_clmul_3x3");
        run_op(0, 2'b00, 32'h8000_0000, 32'd2, 32'h0000_0000, 9, 1'b0, "s4_clmul_msb");
        run_op(0, 2'b01, 32'h8000_0000, 32'd2, 32'h0000_0001, 9, 1'b0, "s4_clmulh_msb");
        run_op(0, 2'b10, 32'h8000_0000, 32'd2, 32'h0000_0002, 9, 1'b0, "s4_clmulr_msb");
        run_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 9, 1'b0, "s4_clmulh_ones");
        run_op(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 9, 1'b0, "s4_clmul_ones");
        run_op(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 9, 1'b0, "s4_clmulr_ones");
        run_op(0, 2'b11, 32'd3, 32'd3, 32'h0000_0005, 9, 1'b0, "s4_op11_3x3");

        // Operands and op scrambled while BUSY; captured values must be used
        run_op(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 9, 1'b1, "s4_scramble");

        // Flush in the third BUSY cycle
        @(negedge clk);
        start_v[0] = 1'b1;
        op  = 2'b00;
        rs1 = 32'd3;
        rs2 = 32'd3;
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 32'(busy_v[0]), 32'd0);
        check("flush_stall", 32'(stall_v[0]), 32'd0);
        check("flush_done", 32'(done_v[0]), 32'd0);
        check("flush_result_hold", result_v[0], 32'h5555_5555);
        d = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            d += int'(done_v[0]);
        end
        check("flush_no_done", 32'(d), 32'd0);

        // Flush wins over start in IDLE
        @(negedge clk);
        start_v[0] = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start_v = '0;
        flush = 1'b0;
        #1;
        check("flush_idle_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        run_op(0, 2'b00, 32'd6, 32'd3, 32'h0000_000A, 9, 1'b0, "s4_after_flush");

        // Reset mid-BUSY abandons the op and clears the result
        @(negedge clk);
        start_v[0] = 1'b1;
        op  = 2'b01;
        rs1 = 32'hFFFF_FFFF;
        rs2 = 32'hFFFF_FFFF;
        @(negedge clk);
        start_v = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_result", result_v[0], 32'd0);
        check("rst_mid_busy", 32'(busy_v[0]), 32'd0);
        check("rst_mid_done", 32'(done_v[0]), 32'd0);
        check("rst_mid_stall", 32'(stall_v[0]), 32'd0);
        d = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            d += int'(done_v[0]);
        end
        check("rst_mid_no_done", 32'(d), 32'd0);
        @(negedge clk);

        // STEP=1 and STEP=32 repeat the first two scenarios
        run_op(1, 2'b00, 32'd3, 32'd3, 32'h0000_0005, 33, 1'b0, "s1_clmul_3x3");
        run_op(1, 2'b00, 32'h8000_0000, 32'd2, 32'h0000_0000, 33, 1'b0, "s1_clmul_msb");
        run_op(1, 2'b01, 32'h8000_0000, 32'd2, 32'h0000_0001, 33, 1'b0, "s1_clmulh_msb");
        run_op(1, 2'b10, 32'h8000_0000, 32'd2, 32'h0000_0002, 33, 1'b0, "s1_clmulr_msb");
        run_op(2, 2'b00, 32'd3, 32'd3, 32'h0000_0005, 2, 1'b0, "s32_clmul_3x3");
        run_op(2, 2'b00, 32'h8000_0000, 32'd2, 32'h0000_0000, 2, 1'b0, "s32_clmul_msb");
        run_op(2, 2'b01, 32'h8000_0000, 32'd2, 32'h0000_0001, 2, 1'b0, "s32_clmulh_msb");
        run_op(2, 2'b10, 32'h8000_0000, 32'd2, 32'h0000_0002, 2, 1'b0, "s32_clmulr_msb");
        run_op(2, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 2, 1'b0, "s32_clmulr_ones");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
